// File: rtl/pc_sequencer.sv
// Program counter with prioritised next-PC selection (exception, eret, stall,
// redirect, sequential), misaligned-target detection and a two-state exception FSM.
module pc_sequencer #(
  parameter int                   data_size    = 32,
  parameter logic [data_size-1:0] RESET_VECTOR = '0,
  parameter logic [data_size-1:0] EXC_VECTOR   = data_size'(32'h8000_0180),
  parameter int                   INSN_BYTES   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [data_size-1:0] branch_target,
  input  logic                 jump,
  input  logic [data_size-1:0] jump_target,
  input  logic                 jr,
  input  logic [data_size-1:0] jr_target,
  input  logic                 exception,
  input  logic                 eret,
  output logic [data_size-1:0] PC_out,
  output logic [data_size-1:0] PC_plus,
  output logic [data_size-1:0] EPC_out,
  output logic [data_size-1:0] bad_vaddr,
  output logic                 exc_level,
  output logic                 addr_err
);

  localparam logic [data_size-1:0] ALIGN_MASK = data_size'(INSN_BYTES - 1);
  localparam logic [data_size-1:0] PC_INC     = data_size'(INSN_BYTES);

  typedef enum logic {NORMAL = 1'b0, IN_EXC = 1'b1} state_e;

  state_e               state_q, state_d;
  logic [data_size-1:0] pc_q, pc_d;
  logic [data_size-1:0] epc_q, epc_d;
  logic [data_size-1:0] bad_vaddr_q, bad_vaddr_d;
  logic                 addr_err_q, addr_err_d;

  logic                 redirect;
  logic [data_size-1:0] target;
  logic                 misalign;
  logic                 take_exc;
  logic                 do_eret;
  logic                 capture_epc;

  // Alignment is only judged on a redirect that would actually commit.
  always_comb begin
    redirect = jr | jump | branch_taken;
    if (jr)        target = jr_target;
    else if (jump) target = jump_target;
    else           target = branch_target;
    misalign = redirect & ~stall & ((target & ALIGN_MASK) != '0);
    take_exc = exception | misalign;
    do_eret  = eret & (state_q == IN_EXC) & ~take_exc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= NORMAL;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      NORMAL: if (take_exc) state_d = IN_EXC;
      IN_EXC: if (do_eret)  state_d = NORMAL;
      default:              state_d = NORMAL;
    endcase
  end

  // No nesting: EPC is captured only on entry from NORMAL.
  always_comb begin
    exc_level   = (state_q == IN_EXC);
    capture_epc = take_exc & (state_q == NORMAL);
  end

  always_comb begin
    pc_d        = pc_q + PC_INC;
    epc_d       = epc_q;
    bad_vaddr_d = bad_vaddr_q;
    addr_err_d  = misalign;
    if (take_exc)      pc_d = EXC_VECTOR;
    else if (do_eret)  pc_d = epc_q;
    else if (stall)    pc_d = pc_q;
    else if (redirect) pc_d = target;
    if (capture_epc) epc_d       = pc_q;
    if (misalign)    bad_vaddr_d = target;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q        <= RESET_VECTOR;
      epc_q       <= '0;
      bad_vaddr_q <= '0;
      addr_err_q  <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      epc_q       <= epc_d;
      bad_vaddr_q <= bad_vaddr_d;
      addr_err_q  <= addr_err_d;
    end
  end

  assign PC_out    = pc_q;
  assign PC_plus   = pc_q + PC_INC;
  assign EPC_out   = epc_q;
  assign bad_vaddr = bad_vaddr_q;
  assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus pushes reference-model results,
// a monitor pops and compares one transaction per clock.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC   = 32'h8000_0180;

  logic        clk = 1'b1;
  logic        reset = 1'b1;
  logic        stall = 1'b0, branch_taken = 1'b0, jump = 1'b0, jr = 1'b0;
  logic        exception = 1'b0, eret = 1'b0;
  logic [31:0] branch_target = '0, jump_target = '0, jr_target = '0;
  logic [31:0] PC_out, PC_plus, EPC_out, bad_vaddr;
  logic        exc_level, addr_err;

  pc_sequencer #(
    .data_size(32), .RESET_VECTOR(RESET_VEC), .EXC_VECTOR(EXC_VEC), .INSN_BYTES(4)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .jr(jr), .jr_target(jr_target),
    .exception(exception), .eret(eret),
    .PC_out(PC_out), .PC_plus(PC_plus), .EPC_out(EPC_out),
    .bad_vaddr(bad_vaddr), .exc_level(exc_level), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, pcp, epc, bva;
    logic        lvl, aerr;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   txn_id    = 0;

  // Reference model state (architectural view of the sequencer)
  logic [31:0] m_pc, m_epc, m_bva;
  logic        m_lvl, m_aerr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push_exp();
    exp_t e;
    e.pc = m_pc; e.pcp = m_pc + 32'd4; e.epc = m_epc; e.bva = m_bva;
    e.lvl = m_lvl; e.aerr = m_aerr;
    sb.push_back(e);
  endtask

  task automatic model_reset();
    m_pc = RESET_VEC; m_epc = '0; m_bva = '0; m_lvl = 1'b0; m_aerr = 1'b0;
  endtask

  task automatic step(input logic st, input logic br, input logic [31:0] bt,
                      input logic jp, input logic [31:0] jt,
                      input logic jrr, input logic [31:0] jrt,
                      input logic ex, input logic er);
    logic        any_redir, mis;
    logic [31:0] t;
    @(negedge clk);
    reset = 1'b1;
    stall = st; branch_taken = br; branch_target = bt; jump = jp; jump_target = jt;
    jr = jrr; jr_target = jrt; exception = ex; eret = er;
    any_redir = jrr | jp | br;
    t   = jrr ? jrt : (jp ? jt : bt);
    mis = any_redir && !st && (t % 4 != 0);
    if (ex || mis) begin
      if (!m_lvl) begin m_epc = m_pc; m_lvl = 1'b1; end
      m_pc = EXC_VEC;
    end else if (er && m_lvl) begin
      m_pc = m_epc; m_lvl = 1'b0;
    end else if (st) begin
      m_pc = m_pc;
    end else if (any_redir) begin
      m_pc = t;
    end else begin
      m_pc = m_pc + 32'd4;
    end
    if (mis) m_bva = t;
    m_aerr = mis;
    push_exp();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic goto(input logic [31:0] a);
    step(0, 0, 0, 1, a, 0, 0, 0, 0);
  endtask

  task automatic hold_reset(input int n, input bit midcycle);
    @(negedge clk);
    if (midcycle) #2;
    reset = 1'b0;
    stall = 0; branch_taken = 0; jump = 0; jr = 0; exception = 0; eret = 0;
    model_reset();
    push_exp();
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      push_exp();
    end
  endtask

  // Asynchronous reset must take effect without waiting for a clock edge.
  always @(negedge reset) begin
    #1;
    chk("async_rst_pc", PC_out, RESET_VEC);
    chk("async_rst_epc", EPC_out, 32'h0);
    chk("async_rst_bva", bad_vaddr, 32'h0);
    chk("async_rst_lvl", 32'(exc_level), 32'h0);
    chk("async_rst_aerr", 32'(addr_err), 32'h0);
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        txn_id++;
        $display("txn %0d: PC_out=%h PC_plus=%h EPC=%h bad_vaddr=%h exc_level=%0d addr_err=%0d",
                 txn_id, PC_out, PC_plus, EPC_out, bad_vaddr, exc_level, addr_err);
        chk("PC_out", PC_out, e.pc);
        chk("PC_plus", PC_plus, e.pcp);
        chk("EPC_out", EPC_out, e.epc);
        chk("bad_vaddr", bad_vaddr, e.bva);
        chk("exc_level", 32'(exc_level), 32'(e.lvl));
        chk("addr_err", 32'(addr_err), 32'(e.aerr));
      end
    end
  end

  initial begin : stimulus
    logic [31:0] tb_t, tj_t, tr_t;
    hold_reset(2, 0);
    idle(); idle(); idle();
    goto(32'h10);
    step(0, 1, 32'h40, 1, 32'h80, 0, 0, 0, 0);     // jump beats branch
    step(1, 0, 0, 0, 0, 1, 32'h200, 0, 0);         // stall holds PC
    goto(32'h20);
    step(0, 0, 0, 0, 0, 1, 32'h102, 0, 0);         // misaligned jr
    idle();
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);               // exception while IN_EXC
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);               // eret back to EPC
    goto(32'h30);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);               // eret in NORMAL ignored
    step(1, 0, 0, 0, 0, 0, 0, 1, 0);               // exception overrides stall
    step(0, 0, 0, 0, 0, 0, 0, 1, 1);               // exception beats eret
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    goto(32'hFFFF_FFFC);
    idle();                                        // wrap to 0
    step(1, 0, 0, 1, 32'h3, 0, 0, 0, 0);           // stalled misaligned target
    step(0, 1, 32'h41, 0, 0, 0, 0, 0, 0);          // misaligned branch
    step(0, 1, 32'h40, 1, 32'h81, 1, 32'h100, 0, 1); // jr aligned beats jump; eret
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        hold_reset(2, 1'($urandom_range(0, 1)));
      end else begin
        tb_t = ($urandom & 32'hFFFF_FFFC) | (($urandom_range(0, 5) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
        tj_t = ($urandom & 32'hFFFF_FFFC) | (($urandom_range(0, 5) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
        tr_t = ($urandom & 32'hFFFF_FFFC) | (($urandom_range(0, 5) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
        step(1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 3) == 0), tb_t,
             1'($urandom_range(0, 5) == 0), tj_t, 1'($urandom_range(0, 6) == 0), tr_t,
             1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 5) == 0));
      end
    end
    goto(32'h50);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle();
    hold_reset(2, 1);                              // mid-cycle reset while IN_EXC
    idle();
    idle();
    @(posedge clk);
    #3;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
